stereo_pan_mixer: RTL and testbench

Downstream consumer of the autopanner's 16-bit pan word. On each sample strobe, it applies the pan value to a mono signed sample and produces a stereo left/right pair. It time-shares a single 16x16 multiplier through a small FSM. A per-sample slew limiter on the pan value suppresses zipper noise when the pan source jumps, for example on an auto-pan enable toggle.

---
 rtl/pan_pkg.sv | 25 ++
 rtl/pan_slew.sv | 39 +++
 rtl/stereo_pan_mixer.sv | 92 +++++++++
 tb/tb_stereo_pan_mixer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pan_pkg.sv
// Shared types and constants for the stereo pan mixer.
package pan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SLEW,
      MUL_L,
      MUL_R,
      DONE
   } state_t;

   localparam logic [15:0] PAN_MAX    = 16'h7FFF;
   localparam logic [15:0] PAN_CENTER = 16'h4000;

   // Pan words above full-right are treated as full-right.
   function automatic logic [15:0] clamp_pan(input logic [15:0] pan);
      return pan[15] ? PAN_MAX : pan;
   endfunction

   // Q15 gain: arithmetic shift (floor) of the 32-bit product, keep 16 bits.
   function automatic logic signed [15:0] scale_q15(input logic signed [31:0] prod);
      return 16'(prod >>> 15);
   endfunction

endpackage

// File: rtl/pan_slew.sv
// Applied-pan register that walks toward the target by at most SLEW_STEP
// per step strobe, landing exactly on the target (no overshoot).
module pan_slew
   import pan_pkg::*;
#(
   parameter logic [15:0] SLEW_STEP = 16'h0040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic [15:0] target,
   output logic [15:0] pan_cur
);

   logic [15:0] up_gap;
   logic [15:0] dn_gap;
   logic [15:0] pan_next;

   // Next applied pan: full step toward target, or snap onto it when close.
   always_comb begin
      up_gap   = target - pan_cur;
      dn_gap   = pan_cur - target;
      pan_next = target;
      if (SLEW_STEP != 16'h0000) begin
         if (target > pan_cur) begin
            if (up_gap > SLEW_STEP) pan_next = pan_cur + SLEW_STEP;
         end else if (target < pan_cur) begin
            if (dn_gap > SLEW_STEP) pan_next = pan_cur - SLEW_STEP;
         end
      end
   end

   // Applied pan updates once per accepted sample, centred after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pan_cur <= PAN_CENTER;
      else if (step) pan_cur <= pan_next;
   end

endmodule

// File: rtl/stereo_pan_mixer.sv
// Mono-to-stereo pan mixer sharing one 16x16 multiplier across the left
// and right gains, sequenced by a five-state FSM.
module stereo_pan_mixer
   import pan_pkg::*;
#(
   parameter logic [15:0] SLEW_STEP = 16'h0040
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   input  logic               SAMPLE_EN,
   input  logic signed [15:0] SAMPLE_IN,
   input  logic        [15:0] PAN_IN,
   output logic signed [15:0] LEFT_OUT,
   output logic signed [15:0] RIGHT_OUT,
   output logic               OUT_VALID,
   output logic               BUSY,
   output logic               OVERRUN
);

   state_t             state;
   state_t             state_next;
   logic signed [15:0] sample_r;
   logic        [15:0] pan_tgt;
   logic        [15:0] pan_cur;
   logic signed [15:0] left_r;
   logic        [15:0] coef;
   logic signed [31:0] prod;

   pan_slew #(
      .SLEW_STEP (SLEW_STEP)
   ) u_slew (
      .clk     (CLOCK_50),
      .rst     (RESET),
      .step    (state == SLEW),
      .target  (pan_tgt),
      .pan_cur (pan_cur)
   );

   // Shared multiplier: left gain is the complement of the applied pan.
   // pan_cur never exceeds 0x7FFF, so coef is a zero-extended 15-bit value.
   always_comb begin
      coef = pan_cur;
      if (state == MUL_L) coef = PAN_MAX - pan_cur;
      prod = sample_r * $signed(coef);
   end

   // FSM state register.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state: one pass IDLE -> SLEW -> MUL_L -> MUL_R -> DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (SAMPLE_EN) state_next = SLEW;
         SLEW:    state_next = MUL_L;
         MUL_L:   state_next = MUL_R;
         MUL_R:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Input capture, left partial result, paired output update, overrun flag.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         sample_r  <= '0;
         pan_tgt   <= PAN_CENTER;
         left_r    <= '0;
         LEFT_OUT  <= '0;
         RIGHT_OUT <= '0;
         OVERRUN   <= 1'b0;
      end else begin
         if (SAMPLE_EN && state == IDLE) begin
            sample_r <= SAMPLE_IN;
            pan_tgt  <= clamp_pan(PAN_IN);
         end
         if (SAMPLE_EN && state != IDLE) OVERRUN <= 1'b1;
         if (state == MUL_L) left_r <= scale_q15(prod);
         if (state == MUL_R) begin
            LEFT_OUT  <= left_r;
            RIGHT_OUT <= scale_q15(prod);
         end
      end
   end

   assign OUT_VALID = (state == DONE);
   assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// Scoreboard bench: a default-slew instance and a no-slew instance share
// the same stimulus; each has its own pan model and expected-result queue.
module tb_stereo_pan_mixer;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en  = 1'b0;
   logic signed [15:0] smp = '0;
   logic        [15:0] pan = '0;

   logic signed [15:0] left_s, right_s, left_f, right_f;
   logic               vld_s, busy_s, ovr_s, vld_f, busy_f, ovr_f;

   int checks = 0;
   int errors = 0;
   int vcnt_s = 0;
   int vcnt_f = 0;

   logic [15:0] cur_s = 16'h4000;
   logic [15:0] cur_f = 16'h4000;
   logic [31:0] q_s[$];
   logic [31:0] q_f[$];

   always #5 clk = ~clk;

   stereo_pan_mixer u_dut_slew (
      .CLOCK_50  (clk),
      .RESET     (rst),
      .SAMPLE_EN (en),
      .SAMPLE_IN (smp),
      .PAN_IN    (pan),
      .LEFT_OUT  (left_s),
      .RIGHT_OUT (right_s),
      .OUT_VALID (vld_s),
      .BUSY      (busy_s),
      .OVERRUN   (ovr_s)
   );

   stereo_pan_mixer #(
      .SLEW_STEP (16'h0000)
   ) u_dut_fast (
      .CLOCK_50  (clk),
      .RESET     (rst),
      .SAMPLE_EN (en),
      .SAMPLE_IN (smp),
      .PAN_IN    (pan),
      .LEFT_OUT  (left_f),
      .RIGHT_OUT (right_f),
      .OUT_VALID (vld_f),
      .BUSY      (busy_f),
      .OVERRUN   (ovr_f)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference Q15 multiply: exact integer product, floor division by 2^15.
   function automatic logic [15:0] mulq(input logic signed [15:0] s, input int unsigned c);
      longint p;
      p = longint'(s) * longint'(c);
      p = p >>> 15;
      return p[15:0];
   endfunction

   function automatic logic [15:0] slew_to(input logic [15:0] cur, input logic [15:0] tgt,
                                           input int unsigned step);
      int unsigned c, t;
      c = cur;
      t = tgt;
      if (step == 0) return tgt;
      if (t > c) return (t - c > step) ? 16'(c + step) : tgt;
      if (t < c) return (c - t > step) ? 16'(c - step) : tgt;
      return tgt;
   endfunction

   task automatic model_accept(input logic signed [15:0] s, input logic [15:0] p);
      logic [15:0] tgt;
      tgt   = (p > 16'h7FFF) ? 16'h7FFF : p;
      cur_s = slew_to(cur_s, tgt, 32'h40);
      cur_f = slew_to(cur_f, tgt, 0);
      q_s.push_back({mulq(s, 32'h7FFF - cur_s), mulq(s, cur_s)});
      q_f.push_back({mulq(s, 32'h7FFF - cur_f), mulq(s, cur_f)});
   endtask

   // Scoreboard: every OUT_VALID pops and compares one expected pair.
   always @(negedge clk) begin
      if (vld_s) begin
         vcnt_s++;
         if (q_s.size() == 0) check_eq("slew_unexpected_valid", q_s.size(), 1);
         else check_eq("slew_lr", {left_s, right_s}, q_s.pop_front());
      end
      if (vld_f) begin
         vcnt_f++;
         if (q_f.size() == 0) check_eq("fast_unexpected_valid", q_f.size(), 1);
         else check_eq("fast_lr", {left_f, right_f}, q_f.pop_front());
      end
   end

   // Returns at the negedge right after the accepting edge.
   task automatic strobe(input logic signed [15:0] s, input logic [15:0] p, input bit accept);
      @(negedge clk);
      en  = 1'b1;
      smp = s;
      pan = p;
      if (accept) model_accept(s, p);
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_s || busy_f) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (busy_s || busy_f) check_eq("idle_timeout", {busy_s, busy_f}, 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      q_s.delete();
      q_f.delete();
      cur_s = 16'h4000;
      cur_f = 16'h4000;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_out_slew", {left_s, right_s}, 0);
      check_eq("rst_out_fast", {left_f, right_f}, 0);
      check_eq("rst_ctrl", {vld_s, busy_s, ovr_s, vld_f, busy_f, ovr_f}, 0);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      apply_reset();

      // Centre pan, with cycle-by-cycle BUSY/OUT_VALID timing.
      strobe(16'sh7FFF, 16'h4000, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check_eq($sformatf("timing_k%0d", k), {vld_f, busy_f, vld_s, busy_s},
                  {(k == 3), (k <= 3), (k == 3), (k <= 3)});
      end
      check_eq("centre_fast", {left_f, right_f}, 32'h3FFE_3FFF);
      check_eq("centre_slew", {left_s, right_s}, 32'h3FFE_3FFF);
      check_eq("centre_one_valid", vcnt_f, 1);

      // Extremes and clamp without slewing.
      strobe(16'sh8000, 16'h7FFF, 1'b1); wait_idle();
      check_eq("full_right", {left_f, right_f}, 32'h0000_8001);
      strobe(16'sh8000, 16'h0000, 1'b1); wait_idle();
      check_eq("full_left", {left_f, right_f}, 32'h8001_0000);
      strobe(16'sh8000, 16'hFFFF, 1'b1); wait_idle();
      check_eq("clamp_right", {left_f, right_f}, 32'h0000_8001);

      // Slew ramp from centre to full right, then back down.
      apply_reset();
      for (int i = 1; i <= 257; i++) begin
         strobe(16'sh7FFF, 16'h7FFF, 1'b1); wait_idle();
         if (i == 1)   check_eq("ramp_first", {left_s, right_s}, 32'h3FBE_403F);
         if (i == 255) check_eq("ramp_255", right_s, 16'h7FBF);
         if (i == 256) check_eq("ramp_256", {left_s, right_s}, 32'h0000_7FFE);
         if (i == 257) check_eq("ramp_hold", {left_s, right_s}, 32'h0000_7FFE);
      end
      strobe(16'sh7FFF, 16'h0000, 1'b1); wait_idle();
      check_eq("descend_1", right_s, 16'h7FBE);
      strobe(16'sh7FFF, 16'h0000, 1'b1); wait_idle();
      check_eq("descend_2", right_s, 16'h7F7E);
      strobe(16'sh7FFF, 16'h0000, 1'b1); wait_idle();
      check_eq("descend_3", right_s, 16'h7F3E);

      // Overrun: strobe two cycles in is dropped; strobe after DONE accepted.
      v0 = vcnt_f;
      check_eq("ovr_clear", {ovr_s, ovr_f}, 0);
      strobe(16'sh2000, 16'h4000, 1'b1);            // now after edge N
      @(negedge clk); en = 1'b1; smp = 16'sh7777; pan = 16'h1111;
      @(negedge clk); en = 1'b0;                    // sampled on N+2
      check_eq("ovr_set", {ovr_s, ovr_f}, 2'b11);
      @(negedge clk);
      @(negedge clk); en = 1'b1; smp = 16'sh4000; pan = 16'h7FFF;
      model_accept(16'sh4000, 16'h7FFF);
      @(negedge clk); en = 1'b0;                    // sampled on N+5
      wait_idle();
      check_eq("ovr_valids", vcnt_f - v0, 2);
      check_eq("ovr_sticky", {ovr_s, ovr_f}, 2'b11);

      // Reset while in MUL_R aborts the sample and recentres the pan.
      v0 = vcnt_s;
      strobe(16'sh1234, 16'h7FFF, 1'b1);
      @(negedge clk);
      @(posedge clk);
      #1;
      apply_reset();
      check_eq("abort_no_valid", vcnt_s - v0, 0);
      strobe(16'sh7FFF, 16'h4000, 1'b1); wait_idle();
      check_eq("post_rst_slew", {left_s, right_s}, 32'h3FFE_3FFF);
      check_eq("post_rst_fast", {left_f, right_f}, 32'h3FFE_3FFF);

      // Random samples and pans against the reference model.
      for (int i = 0; i < 1000; i++) begin
         strobe(16'($urandom), 16'($urandom), 1'b1);
         wait_idle();
      end
      @(negedge clk);

      check_eq("drain_slew", q_s.size(), 0);
      check_eq("drain_fast", q_f.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
